// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundle for the single shared memory port. It carries a req/ready handshake
// with variable latency.
//
// Signals:
//   mem_req    request. Held high until mem_ready is seen.
//   mem_we     write enable. Qualifies mem_req.
//   mem_addr   access address.
//   mem_wdata  store data. Meaningful only when mem_we is high.
//   mem_rdata  read data. Valid in the cycle mem_ready is high.
//   mem_ready  one-cycle completion pulse from the memory.
//
// Modports:
//   master  the arbiter side. It drives the request fields.
//   slave   the memory side. It drives mem_rdata and mem_ready.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// This block arbitrates and sequences the one shared memory port of the
// five-stage pipeline. It serves two requesters:
//   - instruction fetches from the F stage
//   - data loads and stores from the M stage
//
// Each requester is stalled until its own access has completed. The result is
// then presented for exactly one unstalled cycle, so each pipeline register
// advances once per access.
//
// Optional feature (compile-time macro MEM_ARB_RR_EN):
//   defined    a tie in IDLE goes to the requester opposite the last grant.
//              The first tie after reset goes to instruction.
//   undefined  fixed priority. Data always beats instruction.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   IReqF       fetch request
//   PCF         fetch address
//   InstrF      fetched instruction. Valid when IReqF && !IStallF.
//   IStallF     fetch stall (combinational)
//   MemReadM    load request
//   MemWriteM   store request. If both are high, the access is a store.
//   ALUOutM     data address
//   WriteDataM  store data
//   ReadDataM   load data. Valid when MemReadM && !DStallM.
//   DStallM     data stall (combinational)
//   mem         shared memory port (master side). All request fields are
//               registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              IReqF,
    input  logic [ADDR_W-1:0] PCF,
    output logic [DATA_W-1:0] InstrF,
    output logic              IStallF,

    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              DStallM,

    mem_port_arbiter_if.master mem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IDONE = 3'd3,
        DDONE = 3'd4
    } state_t;

    state_t state_reg;

    // Records which requester received the most recent grant (1 = data).
    // Reset leaves it at "data", so the first round-robin tie goes to the fetch.
    logic   last_grant_data_reg;

    logic   data_req;
    logic   tie_to_data;
    logic   grant_data;
    logic   grant_instr;

    assign data_req = MemReadM | MemWriteM;

`ifdef MEM_ARB_RR_EN
    // A tie alternates: the grant goes to the side that did not win last time.
    assign tie_to_data = ~last_grant_data_reg;
`else
    // Fixed priority: data always wins a tie. The flag is still tracked so
    // that both builds see the same grant history. Its value is ignored here.
    assign tie_to_data = 1'b1 | last_grant_data_reg;
`endif

    // Grants are issued only from IDLE. A DONE state always returns to IDLE
    // first, so the pipeline gets its single unstalled cycle before the next
    // access can begin.
    always_comb begin
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        if (state_reg == IDLE) begin
            if (data_req && IReqF) begin
                grant_data  = tie_to_data;
                grant_instr = ~tie_to_data;
            end else if (data_req) begin
                grant_data  = 1'b1;
            end else if (IReqF) begin
                grant_instr = 1'b1;
            end
        end
    end

    // A stall drops only in the requester's own DONE cycle. The losing
    // requester therefore stays stalled through the winner's access and then
    // through its own access.
    assign IStallF = IReqF    && (state_reg != IDONE);
    assign DStallM = data_req && (state_reg != DDONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg           <= IDLE;
            last_grant_data_reg <= 1'b1;
            mem.mem_req         <= 1'b0;
            mem.mem_we          <= 1'b0;
            mem.mem_addr        <= '0;
            mem.mem_wdata       <= '0;
            InstrF              <= '0;
            ReadDataM           <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_data) begin
                        // MemWriteM alone selects the direction. A load and a
                        // store requested together are therefore a store.
                        mem.mem_req         <= 1'b1;
                        mem.mem_we          <= MemWriteM;
                        mem.mem_addr        <= ALUOutM;
                        mem.mem_wdata       <= WriteDataM;
                        last_grant_data_reg <= 1'b1;
                        state_reg           <= DBUSY;
                    end else if (grant_instr) begin
                        mem.mem_req         <= 1'b1;
                        mem.mem_we          <= 1'b0;
                        mem.mem_addr        <= PCF;
                        last_grant_data_reg <= 1'b0;
                        state_reg           <= IBUSY;
                    end
                end

                IBUSY: begin
                    // Request fields stay frozen until the memory responds.
                    if (mem.mem_ready) begin
                        InstrF      <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state_reg   <= IDONE;
                    end
                end

                DBUSY: begin
                    if (mem.mem_ready) begin
                        ReadDataM   <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state_reg   <= DDONE;
                    end
                end

                // The DONE states last exactly one cycle. mem_ready is ignored
                // here and in IDLE, so a spurious pulse never captures data.
                IDONE, DDONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// This bench drives randomized fetch and load/store requesters. Each requester
// holds its request while stalled and moves on once it sees an unstalled
// cycle. A memory model answers with a random latency and also injects
// spurious ready pulses.
//
// A transaction-level reference model tracks the following:
//   - whether an access is outstanding, and its owner and fields
//   - which requester is in its single completion cycle
//   - the last values delivered to each requester
//   - the round-robin history
//
// Every cycle, the DUT outputs are compared against this model. Random
// asynchronous resets are applied during data accesses.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NCYCLES = 3000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          IReqF;
    logic [AW-1:0] PCF;
    logic [DW-1:0] InstrF;
    logic          IStallF;
    logic          MemReadM;
    logic          MemWriteM;
    logic [AW-1:0] ALUOutM;
    logic [DW-1:0] WriteDataM;
    logic [DW-1:0] ReadDataM;
    logic          DStallM;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .IReqF      (IReqF),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .IStallF    (IStallF),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .DStallM    (DStallM),
        .mem        (mem_bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          m_busy;     // an access is outstanding on the port
    bit          m_owner_d;  // owner of the outstanding access (1 = data)
    int          m_done;     // completion cycle: -1 none, 0 fetch, 1 data
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    logic [31:0] m_instr;
    logic [31:0] m_rdata;
    bit          m_last_d;   // last grant went to data
    int          mem_wait;   // memory cycles still to wait before ready
    int          txn;
    int          n_resets;
    int          n_ties;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner_d = 1'b0;
        m_done   = -1;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
        m_instr  = '0;
        m_rdata  = '0;
        m_last_d = 1'b1;
        mem_wait = 0;
    endtask

    task automatic check_cycle();
        check("IStallF",   32'(IReqF && (m_done != 0)), 32'(IStallF));
        check("DStallM",   32'((MemReadM || MemWriteM) && (m_done != 1)), 32'(DStallM));
        check("InstrF",    InstrF, m_instr);
        check("ReadDataM", ReadDataM, m_rdata);
        check("mem_req",   32'(mem_bus.mem_req), 32'(m_busy));
        check("mem_we",    32'(mem_bus.mem_we), 32'(m_busy && m_we));
        if (m_busy) begin
            check("mem_addr", mem_bus.mem_addr, m_addr);
            if (m_owner_d)
                check("mem_wdata", mem_bus.mem_wdata, m_wdata);
        end
    endtask

    // Reset asserted between clock edges: every registered output must clear
    // at once, and the memory drops the abandoned access.
    task automatic mid_reset();
        reset = 1'b0;
        mem_bus.mem_ready = 1'b0;
        #1;
        check("rst_mem_req",   32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_bus.mem_we), 32'd0);
        check("rst_mem_addr",  mem_bus.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_InstrF",    InstrF, 32'd0);
        check("rst_ReadDataM", ReadDataM, 32'd0);
        model_reset();
        n_resets++;
        $display("txn reset during data access (reset %0d)", n_resets);
        @(negedge clock);
        check_cycle();
        reset = 1'b1;
    endtask

    // Requesters change their inputs, the memory responds, and the model
    // advances across the coming rising edge.
    task automatic drive_and_model();
        int  next_done;
        bit  pi;
        bit  pd;
        bit  gd;
        int  kind;

        // Fetch requester: holds while stalled, otherwise picks a new request.
        if (!IReqF || !IStallF) begin
            IReqF = ($urandom_range(0, 3) != 0);
            PCF   = $urandom & 32'hFFFF_FFFC;
        end

        // Data requester.
        if (!(MemReadM || MemWriteM) || !DStallM) begin
            kind       = int'($urandom_range(0, 7));
            MemReadM   = (kind == 1 || kind == 2 || kind == 3 || kind == 7);
            MemWriteM  = (kind == 4 || kind == 5 || kind == 6 || kind == 7);
            ALUOutM    = $urandom & 32'hFFFF_FFFC;
            WriteDataM = $urandom;
        end

        // Memory: answers an outstanding access after mem_wait cycles.
        // While the port is free, it sometimes pulses ready spuriously.
        mem_bus.mem_rdata = (txn == 0) ? 32'h8C82_0004 : $urandom;
        if (m_busy) begin
            if (mem_wait == 0) begin
                mem_bus.mem_ready = 1'b1;
            end else begin
                mem_bus.mem_ready = 1'b0;
                mem_wait--;
            end
        end else begin
            mem_bus.mem_ready = ($urandom_range(0, 4) == 0);
        end

        next_done = -1;
        if (m_busy) begin
            if (mem_bus.mem_ready) begin
                if (m_owner_d) m_rdata = mem_bus.mem_rdata;
                else           m_instr = mem_bus.mem_rdata;
                $display("txn %0d %s addr=%h we=%0d wdata=%h rdata=%h", txn,
                         m_owner_d ? "D" : "I", m_addr, m_we, m_wdata, mem_bus.mem_rdata);
                txn++;
                m_busy    = 1'b0;
                next_done = m_owner_d ? 1 : 0;
            end
        end else if (m_done < 0) begin
            pi = IReqF;
            pd = MemReadM || MemWriteM;
            if (pi || pd) begin
                if (pi && pd) begin
                    n_ties++;
`ifdef MEM_ARB_RR_EN
                    gd = !m_last_d;
`else
                    gd = 1'b1;
`endif
                end else begin
                    gd = pd;
                end
                m_busy    = 1'b1;
                m_owner_d = gd;
                m_last_d  = gd;
                m_addr    = gd ? ALUOutM : PCF;
                m_we      = gd && MemWriteM;
                if (gd) m_wdata = WriteDataM;
                mem_wait  = (txn == 0) ? 1 : int'($urandom_range(0, 3));
            end
        end
        m_done = next_done;
    endtask

    initial begin
        txn      = 0;
        n_resets = 0;
        n_ties   = 0;
        model_reset();
        IReqF      = 1'b1;
        PCF        = 32'h40;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;

        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_cycle();
        check("reset_mem_addr",  mem_bus.mem_addr, 32'd0);
        check("reset_mem_wdata", mem_bus.mem_wdata, 32'd0);
        reset = 1'b1;
        drive_and_model();

        for (int n = 0; n < NCYCLES; n++) begin
            @(negedge clock);
            check_cycle();
            if (m_busy && m_owner_d && n_resets < 8 && $urandom_range(0, 29) == 0)
                mid_reset();
            drive_and_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
